mult8_seq_ctrl: RTL and testbench
=================================

Name: mult8_seq_ctrl

Overview:
- Sequencer that computes an 8x8 product by time-multiplexing one instance of the team's existing 4x4 Wallace-tree multiplier (`wallace`) over four nibble-product cycles.
- Provides a start/busy/done handshake and optional two's-complement signed mode.
- Sits between the calculator's operand/opcode decode and the result register, as the MUL execution unit.

Parameters:
- SIGNED_SUPPORT, 1, 1 = honour `signed_mode`; 0 = `signed_mode` is ignored and every operation is unsigned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = operands and result are two's complement; sampled with `start`.
- a  input  8  multiplicand; sampled with `start`.
- b  input  8  multiplier; sampled with `start`.
- busy  output  1  high while an operation is in progress (states PP0..FIN).
- done  output  1  single-cycle completion pulse.
- product  output  16  result; holds its value until the next completion.

Behaviour:
- Reset: synchronous and active-high. While `rst` is high at a clock edge:
  - state goes to IDLE; `busy` = 0; `done` = 0; `product` = 16'h0000;
  - accumulator and operand registers are cleared.
  - Reset overrides `start` and any operation in flight. No partial result is ever written to `product`.
- States: IDLE -> PP0 -> PP1 -> PP2 -> PP3 -> FIN -> IDLE.
  - The only branch is IDLE -> PP0, taken when `start` = 1. Every other transition is unconditional.
- Load (IDLE with `start` = 1, edge at the end of cycle N):
  - `neg = signed_mode & SIGNED_SUPPORT & (a[7] ^ b[7])`.
  - In signed mode, `ma = |a|` and `mb = |b|`. Magnitudes are 8-bit unsigned, so -128 gives 8'h80.
  - In unsigned mode, `ma = a` and `mb = b`.
  - Accumulator `acc` (16 bits) is set to 0.
- Partial products: one per cycle from the single `wallace` instance; `acc` updates at the end of each cycle.
  - PP0: `ma[3:0]*mb[3:0]`, added with shift 0.
  - PP1: `ma[7:4]*mb[3:0]`, added with shift 4.
  - PP2: `ma[3:0]*mb[7:4]`, added with shift 4.
  - PP3: `ma[7:4]*mb[7:4]`, added with shift 8.
  - Additions are 16 bits wide and cannot overflow (max 255*255 = 65025).
- FIN: `product <= neg ? (~acc + 1) : acc`, and `done <= 1`.
  - Max signed magnitude is 128*128 = 16384, so the signed result always fits in 16 bits.
- Timing:
  - `busy` is high in cycles N+1..N+5.
  - `done` is high in cycle N+6 only. In that cycle the state is IDLE and `product` is valid.
  - Total latency is 6 cycles from the `start` sample edge to `done`.
- `start` while `busy` = 1 is ignored: no queuing, and operand changes during busy have no effect.
- `start` in the same cycle that `done` is high is accepted (back-to-back). Throughput is one result per 6 cycles.
- `product` changes only at FIN or on reset. It is stable across IDLE and the next operation's busy period.
- A zero operand runs the full sequence; in signed mode the result is 0 (negating 0 yields 0).
- The `wallace` inputs are driven to 0 in IDLE and FIN so the combinational tree does not toggle needlessly.

Decomposition:
- Shared package `calc_pkg`:
  - state enum: IDLE, PP0, PP1, PP2, PP3, FIN (3-bit encoding);
  - constants: `OPW=8`, `NIBW=4`, `PRODW=16`, `MUL_LATENCY=6`.
- Sub-module: `wallace` (existing, reused unchanged) is the single datapath resource.
- Nibble-select mux, shift/accumulate and sign fix-up stay inline in `mult8_seq_ctrl`.

Test Plan:
- Reset then idle: `product`=0, `busy`=0, `done`=0. Unsigned 13*11 -> `done` exactly 6 cycles after the start edge, `product`=16'h008F (143); `busy` high for exactly 5 cycles.
- Unsigned 255*255 -> `product`=16'hFE01. Unsigned 0*200 -> 16'h0000.
- Signed (-128)*(-128) -> 16'h4000. Signed (-3)*5 -> 16'hFFF1. Signed 127*(-128) -> 16'hC080.
- `start` held high with changing `a`/`b` during busy -> only the first operands are used, and exactly one `done` pulse.
- Back-to-back: assert `start` (7*9) during the `done` cycle of 2*3 -> first `product`=6, and 6 cycles later `product`=63. `product` holds 6 in between.
- `rst` asserted in PP2 of 100*100 -> next cycle IDLE, `busy`=0, `product`=0, and no `done`. A subsequent 4*4 gives 16.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand/product widths, MUL latency and the
// sequencer state encoding, plus a small two's-complement magnitude helper.
package calc_pkg;

  localparam int OPW         = 8;
  localparam int NIBW        = 4;
  localparam int PRODW       = 16;
  localparam int MUL_LATENCY = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    FIN  = 3'd5
  } state_t;

  // -128 maps to 8'h80, which is the correct unsigned magnitude.
  function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] v);
    return v[OPW-1] ? (~v + OPW'(1)) : v;
  endfunction

endpackage

// File: rtl/wallace.sv
// 4x4 unsigned multiplier: four partial products reduced by two 3:2
// carry-save layers and one final carry-propagate add.
module wallace (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s1, c1, s2, c2;

  assign pp0 = {4'b0000, a & {4{b[0]}}};
  assign pp1 = {3'b000,  a & {4{b[1]}}, 1'b0};
  assign pp2 = {2'b00,   a & {4{b[2]}}, 2'b00};
  assign pp3 = {1'b0,    a & {4{b[3]}}, 3'b000};

  // The product never exceeds 225, so carries shifted out of bit 7 are zero.
  assign s1 = pp0 ^ pp1 ^ pp2;
  assign c1 = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
  assign s2 = s1 ^ c1 ^ pp3;
  assign c2 = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
  assign p  = s2 + c2;

endmodule

// File: rtl/mult8_seq_ctrl.sv
// MUL execution unit: 8x8 multiply in four nibble-product cycles on one shared
// 4x4 multiplier, with start/busy/done handshake and optional signed mode.
module mult8_seq_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned SIGNED_SUPPORT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [PRODW-1:0] product
);

  state_t state, next_state;

  logic [OPW-1:0]    ma, mb;
  logic              neg;
  logic              sgn;
  logic [PRODW-1:0]  acc;
  logic [PRODW-1:0]  addend;
  logic [NIBW-1:0]   wa, wb;
  logic [2*NIBW-1:0] wp;

  assign sgn  = signed_mode & (SIGNED_SUPPORT != 0);
  assign busy = (state != IDLE);

  wallace u_wallace (
    .a (wa),
    .b (wb),
    .p (wp)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    wa         = '0;
    wb         = '0;
    unique case (state)
      IDLE: if (start) next_state = PP0;
      PP0: begin wa = ma[3:0]; wb = mb[3:0]; next_state = PP1; end
      PP1: begin wa = ma[7:4]; wb = mb[3:0]; next_state = PP2; end
      PP2: begin wa = ma[3:0]; wb = mb[7:4]; next_state = PP3; end
      PP3: begin wa = ma[7:4]; wb = mb[7:4]; next_state = FIN; end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Kept apart from the mux block so the tree output never feeds back into it.
  always_comb begin
    addend = '0;
    unique case (state)
      PP0:      addend = PRODW'(wp);
      PP1, PP2: addend = PRODW'(wp) << 4;
      PP3:      addend = PRODW'(wp) << 8;
      default:  addend = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ma      <= '0;
      mb      <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          ma  <= sgn ? mag(a) : a;
          mb  <= sgn ? mag(b) : b;
          neg <= sgn & (a[OPW-1] ^ b[OPW-1]);
          acc <= '0;
        end
        PP0, PP1, PP2, PP3: acc <= acc + addend;
        FIN: begin
          product <= neg ? (~acc + PRODW'(1)) : acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: directed table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  mult8_seq_ctrl #(.SIGNED_SUPPORT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic sm, input logic [7:0] x, input logic [7:0] y);
    int r;
    if (sm) r = int'($signed(x)) * int'($signed(y));
    else    r = int'(x) * int'(y);
    return r[15:0];
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 into the done cycle.
  task automatic run_op(input logic sm, input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] prod, output int lat, output int busy_cnt);
    start = 1'b1; signed_mode = sm; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin lat = i; break; end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    prod = product;
  endtask

  initial begin
    logic [15:0] prod;
    int lat, bcnt, pulses;
    bit hold_ok;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'h008F};
    vecs[1] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{1'b0, 8'd0,   8'd200, 16'h0000};
    vecs[3] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[4] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
    vecs[5] = '{1'b1, 8'h7F,  8'h80,  16'hC080};
    vecs[6] = '{1'b1, 8'h00,  8'hFB,  16'h0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_product", 32'(product), 32'h0);
    check("reset_busy",    32'(busy),    32'h0);
    check("reset_done",    32'(done),    32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'h0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sm, vecs[i].a, vecs[i].b, prod, lat, bcnt);
      check($sformatf("vec%0d_product", i), 32'(prod), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd5);
      check($sformatf("vec%0d_busy_in_done", i), 32'(busy), 32'h0);
    end

    // start held high with changing operands during busy
    start = 1'b1; signed_mode = 1'b0; a = 8'd6; b = 8'd7;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom); start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("held_done", 32'(done), 32'h1);
    check("held_product", 32'(product), 32'd42);
    pulses = done ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("held_done_pulses", 32'(pulses), 32'd1);

    // Back-to-back: second start in the done cycle of the first
    run_op(1'b0, 8'd2, 8'd3, prod, lat, bcnt);
    check("b2b_first_product", 32'(prod), 32'd6);
    start = 1'b1; signed_mode = 1'b0; a = 8'd7; b = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    hold_ok = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin lat = i; break; end
      if (product !== 16'd6) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_product_hold", 32'(hold_ok), 32'h1);
    check("b2b_latency", 32'(lat), 32'd6);
    check("b2b_second_product", 32'(product), 32'd63);

    // Reset during PP2 of 100*100
    start = 1'b1; signed_mode = 1'b0; a = 8'd100; b = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy",    32'(busy),    32'h0);
    check("midrst_done",    32'(done),    32'h0);
    check("midrst_product", 32'(product), 32'h0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'h0);
    run_op(1'b0, 8'd4, 8'd4, prod, lat, bcnt);
    check("post_rst_product", 32'(prod), 32'd16);
    check("post_rst_latency", 32'(lat), 32'd6);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic       sm;
      logic [7:0] x, y;
      sm = 1'($urandom);
      x  = 8'($urandom);
      y  = 8'($urandom);
      run_op(sm, x, y, prod, lat, bcnt);
      check($sformatf("rnd%0d_sm%0d_%0h_x_%0h", i, sm, x, y), 32'(prod), 32'(ref_mul(sm, x, y)));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
